down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter and load-data width in bits; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 clr  input  1  reset, asynchronous and active-low: clr=0 clears immediately, independent of clk.
REQ-004 load  input  1  synchronous load strobe, sampled on the rising edge of clk.
REQ-005 d  input  WIDTH  load value, captured when load=1.
REQ-006 en  input  1  count enable; one decrement per rising edge while counting.
REQ-007 periodic  input  1  1 = auto-reload at terminal count; 0 = one-shot.
REQ-008 q  output  WIDTH  current count value, registered.
REQ-009 qbar  output  WIDTH  bitwise complement of q, driven from the same register.
REQ-010 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-011 busy  output  1  1 while the FSM is in COUNT.

Function
REQ-012 FSM states: IDLE and COUNT; an internal WIDTH-bit reload register holds the last loaded d.
REQ-013 load=1, any state: on that edge, q<=d and reload<=d; next state is COUNT if d!=0, else IDLE; tc=0.
REQ-014 IDLE, load=0: q holds its value, tc=0, en is ignored.
REQ-015 COUNT, en=0, load=0: q holds its value, tc=0, state unchanged.
REQ-016 COUNT, en=1, load=0, q>1: q<=q-1, tc=0.
REQ-017 COUNT, en=1, load=0, q==1: q<=0 and tc<=1 on that edge; next state is COUNT if periodic=1, else IDLE.
REQ-018 COUNT, en=1, load=0, q==0 (periodic case): q<=reload, tc=0, state stays COUNT.
REQ-019 Period in periodic mode is reload+1 enabled cycles: N, N-1, ..., 1, 0, N, and so on.
REQ-020 A simultaneous load and terminal condition resolves in favour of load: no tc, reload updated.
REQ-021 periodic is sampled only on the edge where q goes 1->0; changing it mid-count has no other effect.
REQ-022 Decrement is modulo 2^WIDTH, but the FSM never decrements from 0, so q never wraps to all-ones.
REQ-023 Latency: q, qbar, tc and busy all reflect an input on the first rising edge after it is sampled; there is no combinational path from input to output.
REQ-024 qbar equals ~q at every instant, including during reset.

Reset
REQ-025 When clr=0: q=0, qbar=all-ones, tc=0, busy=0, reload=0, state=IDLE, asynchronously.
REQ-026 When clr rises, the first active edge obeys REQ-013..018; load on that first edge is honoured.
REQ-027 Reset asserted mid-count aborts the count with no tc pulse; reload is lost.

Structure
REQ-028 A shared package holds the FSM state typedef (IDLE, COUNT) and the default WIDTH constant.
REQ-029 One sub-module, dff_vec (a WIDTH-bit D register with async active-low clr, outputs q/qbar), holds the count; FSM, reload register and next-value logic stay in down_counter.

Verification
REQ-030 clr=0 for 5 ns while load=1, d=4'hF -> q=0, qbar=4'hF, tc=0 and busy=0 for the whole reset window.
REQ-031 WIDTH=4, load d=3, periodic=0, en=1 -> q sequence 3,2,1,0; tc=1 only on the edge where q reaches 0; busy then 0 and q holds 0.
REQ-032 load d=2, periodic=1, en=1 for 9 cycles -> q: 2,1,0,2,1,0,2,1,0; tc pulses exactly 3 times.
REQ-033 load d=5, en toggled 1,0,0,1 -> q: 5,4,4,4,3; tc stays 0.
REQ-034 q=1, en=1, load=1 with d=6 on the same edge -> q=6, tc=0, busy=1.
REQ-035 clr pulled low asynchronously (between edges) while q=3 -> q=0 immediately, no tc; after release, load d=0 -> q=0, busy=0.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the down_counter block: FSM state encoding and default width.
package down_counter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/dff_vec.sv
// WIDTH-bit D register with asynchronous active-low clear; qbar is the complement of the same flops.
module dff_vec #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) q <= '0;
    else      q <= d;
  end

  assign qbar = ~q;

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with one-shot or auto-reload operation and a registered terminal-count pulse.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             tc,
  output logic             busy
);

  state_t           state;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] q_next;
  logic             q_is_one;

  assign q_is_one = (q == WIDTH'(1));

  // Count register next value; load wins over any counting action.
  always_comb begin
    q_next = q;
    if (load) begin
      q_next = d;
    end else if (state == COUNT && en) begin
      if (q == '0) q_next = reload;
      else         q_next = q - WIDTH'(1);
    end
  end

  dff_vec #(.WIDTH(WIDTH)) u_count (
    .clk  (clk),
    .clr  (clr),
    .d    (q_next),
    .q    (q),
    .qbar (qbar)
  );

  // periodic only matters on the 1->0 edge; it decides whether the FSM keeps counting.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state  <= IDLE;
      tc     <= 1'b0;
      reload <= '0;
    end else begin
      tc <= 1'b0;
      if (load) begin
        reload <= d;
        state  <= (d != '0) ? COUNT : IDLE;
      end else if (state == COUNT && en && q_is_one) begin
        tc <= 1'b1;
        if (!periodic) state <= IDLE;
      end
    end
  end

  // busy is the state register itself, so it doubles as the FSM debug view.
  assign busy = (state == COUNT);

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: a vector table for the per-edge behaviour plus hand sequences for reset corners.
module tb_down_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr;
  logic         load;
  logic [W-1:0] d;
  logic         en;
  logic         periodic;
  logic [W-1:0] q;
  logic [W-1:0] qbar;
  logic         tc;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic         load;
    logic [W-1:0] d;
    logic         en;
    logic         periodic;
    logic [W-1:0] exp_q;
    logic         exp_tc;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];

  down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr      (clr),
    .load     (load),
    .d        (d),
    .en       (en),
    .periodic (periodic),
    .q        (q),
    .qbar     (qbar),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] eq, input logic etc, input logic ebusy);
    logic [W-1:0] eqb;
    eqb = ~eq;
    check({tag, ".q"}, 16'(q), 16'(eq));
    check({tag, ".qbar"}, 16'(qbar), 16'(eqb));
    check({tag, ".tc"}, 16'(tc), 16'(etc));
    check({tag, ".busy"}, 16'(busy), 16'(ebusy));
  endtask

  task automatic add(input logic l, input logic [W-1:0] dv, input logic e, input logic p,
                     input logic [W-1:0] eq, input logic etc, input logic eb);
    vec_t v;
    v.load = l; v.d = dv; v.en = e; v.periodic = p;
    v.exp_q = eq; v.exp_tc = etc; v.exp_busy = eb;
    vecs.push_back(v);
  endtask

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic step(input logic l, input logic [W-1:0] dv, input logic e, input logic p);
    @(negedge clk);
    load = l; d = dv; en = e; periodic = p;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // one-shot d=3: 3,2,1,0 with tc on the edge reaching 0, then hold at 0 in IDLE
    add(1, 4'd3, 1, 0, 4'd3, 0, 1);
    add(0, 4'd0, 1, 0, 4'd2, 0, 1);
    add(0, 4'd0, 1, 0, 4'd1, 0, 1);
    add(0, 4'd0, 1, 0, 4'd0, 1, 0);
    add(0, 4'd0, 1, 0, 4'd0, 0, 0);
    add(0, 4'd0, 1, 1, 4'd0, 0, 0);
    // periodic d=2: 2,1,0,2,1,0,2,1,0 with three tc pulses
    add(1, 4'd2, 1, 1, 4'd2, 0, 1);
    add(0, 4'd0, 1, 1, 4'd1, 0, 1);
    add(0, 4'd0, 1, 1, 4'd0, 1, 1);
    add(0, 4'd0, 1, 1, 4'd2, 0, 1);
    add(0, 4'd0, 1, 1, 4'd1, 0, 1);
    add(0, 4'd0, 1, 1, 4'd0, 1, 1);
    add(0, 4'd0, 1, 1, 4'd2, 0, 1);
    add(0, 4'd0, 1, 1, 4'd1, 0, 1);
    add(0, 4'd0, 1, 1, 4'd0, 1, 1);
    // d=5 with en 1,0,0,1: 5,4,4,4,3 and no tc
    add(1, 4'd5, 0, 0, 4'd5, 0, 1);
    add(0, 4'd0, 1, 0, 4'd4, 0, 1);
    add(0, 4'd0, 0, 0, 4'd4, 0, 1);
    add(0, 4'd0, 0, 0, 4'd4, 0, 1);
    add(0, 4'd0, 1, 0, 4'd3, 0, 1);
    add(0, 4'd0, 1, 0, 4'd2, 0, 1);
    add(0, 4'd0, 1, 0, 4'd1, 0, 1);
    // load d=6 on the same edge as the terminal condition: load wins, no tc
    add(1, 4'd6, 1, 0, 4'd6, 0, 1);
    // periodic toggled mid-count is irrelevant; only its value at the 1->0 edge counts
    add(0, 4'd0, 1, 1, 4'd5, 0, 1);
    add(0, 4'd0, 1, 0, 4'd4, 0, 1);
    add(0, 4'd0, 1, 1, 4'd3, 0, 1);
    add(0, 4'd0, 1, 1, 4'd2, 0, 1);
    add(0, 4'd0, 1, 1, 4'd1, 0, 1);
    add(0, 4'd0, 1, 0, 4'd0, 1, 0);
    // max load value, then load of zero returns to IDLE
    add(1, 4'hF, 0, 0, 4'hF, 0, 1);
    add(0, 4'd0, 1, 0, 4'hE, 0, 1);
    add(1, 4'd0, 1, 1, 4'd0, 0, 0);
    // periodic with reload=1: period of two cycles, tc every other edge
    add(1, 4'd1, 1, 1, 4'd1, 0, 1);
    add(0, 4'd0, 1, 1, 4'd0, 1, 1);
    add(0, 4'd0, 1, 1, 4'd1, 0, 1);
    add(0, 4'd0, 1, 1, 4'd0, 1, 1);
    add(0, 4'd0, 1, 0, 4'd1, 0, 1);
    add(0, 4'd0, 1, 0, 4'd0, 1, 0);

    // reset window with load=1, d=F held
    clr = 1'b0; load = 1'b1; d = 4'hF; en = 1'b1; periodic = 1'b0;
    #1;
    check_all("rst_t1", 4'd0, 0, 0);
    @(posedge clk);
    #1;
    check_all("rst_edge", 4'd0, 0, 0);
    @(negedge clk);
    check_all("rst_end", 4'd0, 0, 0);
    clr = 1'b1; load = 1'b0; d = 4'd0; en = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].load, vecs[i].d, vecs[i].en, vecs[i].periodic);
      check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc, vecs[i].exp_busy);
    end

    // load on the very first edge after reset release is honoured
    @(negedge clk);
    clr = 1'b0;
    load = 1'b1; d = 4'd7; en = 1'b0; periodic = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_edge_load", 4'd7, 0, 1);

    // async clear between edges mid-count
    step(1, 4'd5, 0, 0);
    step(0, 4'd0, 1, 1);
    step(0, 4'd0, 1, 1);
    check_all("pre_async", 4'd3, 0, 1);
    #2;
    clr = 1'b0;
    #1;
    check_all("async_clr", 4'd0, 0, 0);
    @(posedge clk);
    #1;
    check_all("async_hold", 4'd0, 0, 0);
    @(negedge clk);
    clr = 1'b1;
    // reload was lost and the FSM is IDLE, so en alone does nothing
    step(0, 4'd0, 1, 1);
    check_all("post_rst_idle", 4'd0, 0, 0);
    step(1, 4'd0, 1, 1);
    check_all("post_rst_load0", 4'd0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
